// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : step_pulse_gen
// Brief    : Debounced push-button front end producing press/release strobes,
//            a stretched single-step pulse and a wrapping press counter.
// Revision : 1.0 - initial release
// ============================================================================
module step_pulse_gen #(
    parameter int SAMPLE_DIV = 100000,
    parameter int DB_SAMPLES = 10,
    parameter int STEP_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw,
    output logic        btn_level,
    output logic        press,
    output logic        release_stb,   // "release" is a reserved word
    output logic        step_pulse,
    output logic [15:0] press_cnt
);

    localparam int               c_div_w    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SAMPLE_DIV - 1);
    localparam logic [7:0]       c_db_last  = 8'(DB_SAMPLES - 1);
    localparam logic [7:0]       c_step_w   = 8'(STEP_W);
    localparam bit               c_db_one   = (DB_SAMPLES == 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_HELD      = 2'd2,
        S_REL_CHK   = 2'd3
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    logic [c_div_w-1:0] r_div_cnt;
    state_t             r_state;
    logic [7:0]         r_scnt;
    logic               r_level;
    logic               r_press;
    logic               r_release;
    logic [15:0]        r_press_cnt;
    logic [7:0]         r_stretch;
    logic               r_step;

    logic               w_tick;
    logic               w_accept_press;
    logic               w_accept_release;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running sample prescaler; never resynchronised to button activity.
    assign w_tick = (r_div_cnt == c_div_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_w'(1);
        end
    end

    // Accept fires on the sample that completes DB_SAMPLES equal readings.
    assign w_accept_press   = w_tick && r_sync2 &&
                              ((r_state == S_IDLE && c_db_one) ||
                               (r_state == S_PRESS_CHK && r_scnt >= c_db_last));
    assign w_accept_release = w_tick && !r_sync2 &&
                              ((r_state == S_HELD && c_db_one) ||
                               (r_state == S_REL_CHK && r_scnt >= c_db_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_scnt      <= 8'd0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_press_cnt <= 16'd0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_accept_press) begin
                r_state     <= S_HELD;
                r_scnt      <= 8'd0;
                r_level     <= 1'b1;
                r_press     <= 1'b1;
                r_press_cnt <= r_press_cnt + 16'd1;
            end else if (w_accept_release) begin
                r_state   <= S_IDLE;
                r_scnt    <= 8'd0;
                r_level   <= 1'b0;
                r_release <= 1'b1;
            end else if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (r_sync2) begin
                            r_state <= S_PRESS_CHK;
                            r_scnt  <= 8'd1;
                        end
                    end
                    S_PRESS_CHK: begin
                        if (!r_sync2) begin
                            r_state <= S_IDLE;
                            r_scnt  <= 8'd0;
                        end else begin
                            r_scnt <= r_scnt + 8'd1;
                        end
                    end
                    S_HELD: begin
                        if (!r_sync2) begin
                            r_state <= S_REL_CHK;
                            r_scnt  <= 8'd1;
                        end
                    end
                    S_REL_CHK: begin
                        if (r_sync2) begin
                            r_state <= S_HELD;
                            r_scnt  <= 8'd0;
                        end else begin
                            r_scnt <= r_scnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_scnt  <= 8'd0;
                    end
                endcase
            end
        end
    end

    // r_stretch holds the clocks still to run; r_step is its registered "nonzero".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stretch <= 8'd0;
            r_step    <= 1'b0;
        end else if (w_accept_press) begin
            r_stretch <= c_step_w;
            r_step    <= 1'b1;
        end else if (r_stretch != 8'd0) begin
            r_stretch <= r_stretch - 8'd1;
            r_step    <= (r_stretch > 8'd1);
        end
    end

    assign btn_level   = r_level;
    assign press       = r_press;
    assign release_stb = r_release;
    assign step_pulse  = r_step;
    assign press_cnt   = r_press_cnt;

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_pulse_gen
// Brief    : Directed self-checking bench for step_pulse_gen (two configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_pulse_gen;

    localparam int c_sel_a_press = 0;
    localparam int c_sel_a_rel   = 1;
    localparam int c_sel_b_press = 2;
    localparam int c_sel_b_rel   = 3;

    logic        clk;
    logic        rst;
    logic        btn_a;
    logic        a_level, a_press, a_rel, a_step;
    logic [15:0] a_cnt;
    logic        btn_b;
    logic        b_level, b_press, b_rel, b_step;
    logic [15:0] b_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int a_np = 0, a_nr = 0, a_both = 0, b_both = 0;

    step_pulse_gen #(.SAMPLE_DIV(4), .DB_SAMPLES(3), .STEP_W(4)) dut_a (
        .clk(clk), .rst(rst), .btn_raw(btn_a), .btn_level(a_level), .press(a_press),
        .release_stb(a_rel), .step_pulse(a_step), .press_cnt(a_cnt)
    );

    step_pulse_gen #(.SAMPLE_DIV(4), .DB_SAMPLES(1), .STEP_W(1)) dut_b (
        .clk(clk), .rst(rst), .btn_raw(btn_b), .btn_level(b_level), .press(b_press),
        .release_stb(b_rel), .step_pulse(b_step), .press_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_press) a_np <= a_np + 1;
        if (a_rel) a_nr <= a_nr + 1;
        if (a_press && a_rel) a_both <= a_both + 1;
        if (b_press && b_rel) b_both <= b_both + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input int sel, input int max_cyc, output int cyc, output bit seen);
        logic s;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            case (sel)
                c_sel_a_press: s = a_press;
                c_sel_a_rel:   s = a_rel;
                c_sel_b_press: s = b_press;
                default:       s = b_rel;
            endcase
            if (s) seen = 1'b1;
        end
    endtask

    initial begin
        int cyc;
        bit seen;
        rst   = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_level", 32'(a_level), 0);
        check_eq("rst_press", 32'(a_press), 0);
        check_eq("rst_release", 32'(a_rel), 0);
        check_eq("rst_step", 32'(a_step), 0);
        check_eq("rst_cnt", 32'(a_cnt), 0);
        check_eq("rst_b_level", 32'(b_level), 0);
        rst = 1'b0;

        // Single-sample config: one high tick then one low tick
        btn_b = 1'b1;
        wait_strobe(c_sel_b_press, 20, cyc, seen);
        check_eq("b_press_seen", 32'(seen), 1);
        check_eq("b_step_on", 32'(b_step), 1);
        check_eq("b_level_hi", 32'(b_level), 1);
        btn_b = 1'b0;
        @(negedge clk);
        check_eq("b_step_off", 32'(b_step), 0);
        check_eq("b_press_off", 32'(b_press), 0);
        wait_strobe(c_sel_b_rel, 20, cyc, seen);
        check_eq("b_rel_seen", 32'(seen), 1);
        check_eq("b_level_lo", 32'(b_level), 0);
        check_eq("b_cnt", 32'(b_cnt), 1);

        // Clean press
        btn_a = 1'b1;
        wait_strobe(c_sel_a_press, 40, cyc, seen);
        check_eq("press_seen", 32'(seen), 1);
        check_eq("press_step", 32'(a_step), 1);
        check_eq("press_level", 32'(a_level), 1);
        check_eq("press_cnt1", 32'(a_cnt), 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check_eq("step_hold", 32'(a_step), 1);
            check_eq("press_once", 32'(a_press), 0);
        end
        @(negedge clk);
        check_eq("step_end", 32'(a_step), 0);
        repeat (20) @(negedge clk);
        check_eq("np_clean", 32'(a_np), 1);

        // Clean release
        btn_a = 1'b0;
        wait_strobe(c_sel_a_rel, 40, cyc, seen);
        check_eq("rel_seen", 32'(seen), 1);
        check_eq("rel_level", 32'(a_level), 0);
        repeat (20) @(negedge clk);
        check_eq("nr_clean", 32'(a_nr), 1);

        // Bounce: toggling every 3 clks never gives 3 equal samples
        for (int i = 0; i < 40; i++) begin
            btn_a = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        btn_a = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("bounce_np", 32'(a_np), 1);
        check_eq("bounce_level", 32'(a_level), 0);
        check_eq("bounce_cnt", 32'(a_cnt), 1);

        // 8 clks high covers exactly two samples: 1,1,0 pattern
        btn_a = 1'b1;
        repeat (8) @(negedge clk);
        btn_a = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("p110_np", 32'(a_np), 1);
        check_eq("p110_level", 32'(a_level), 0);

        // Release bounce while held
        btn_a = 1'b1;
        wait_strobe(c_sel_a_press, 40, cyc, seen);
        check_eq("held_seen", 32'(seen), 1);
        repeat (10) @(negedge clk);
        btn_a = 1'b0;
        repeat (4) @(negedge clk);
        btn_a = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("relb_nr", 32'(a_nr), 1);
        check_eq("relb_level", 32'(a_level), 1);
        btn_a = 1'b0;
        wait_strobe(c_sel_a_rel, 40, cyc, seen);
        check_eq("relb_seen", 32'(seen), 1);
        repeat (20) @(negedge clk);
        check_eq("relb_nr2", 32'(a_nr), 2);

        // Counter wrap
        force dut_a.r_press_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_a.r_press_cnt;
        @(negedge clk);
        check_eq("wrap_pre", 32'(a_cnt), 32'h0000FFFF);
        btn_a = 1'b1;
        wait_strobe(c_sel_a_press, 40, cyc, seen);
        check_eq("wrap_seen", 32'(seen), 1);
        check_eq("wrap_cnt", 32'(a_cnt), 0);
        btn_a = 1'b0;
        wait_strobe(c_sel_a_rel, 40, cyc, seen);
        check_eq("wrap_rel", 32'(seen), 1);
        repeat (10) @(negedge clk);

        // Async reset during second clk of step_pulse
        btn_a = 1'b1;
        wait_strobe(c_sel_a_press, 40, cyc, seen);
        check_eq("ar_seen", 32'(seen), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_step", 32'(a_step), 0);
        check_eq("ar_level", 32'(a_level), 0);
        check_eq("ar_cnt", 32'(a_cnt), 0);
        check_eq("ar_b_cnt", 32'(b_cnt), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_strobe(c_sel_a_press, 40, cyc, seen);
        check_eq("ar_repress", 32'(seen), 1);
        check_eq("ar_latency", 32'(cyc), 12);
        check_eq("ar_cnt1", 32'(a_cnt), 1);
        btn_a = 1'b0;
        wait_strobe(c_sel_a_rel, 40, cyc, seen);
        check_eq("ar_rel", 32'(seen), 1);

        check_eq("a_no_overlap", 32'(a_both), 0);
        check_eq("b_no_overlap", 32'(b_both), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
